command_frame_serializer_hcp: RTL and testbench

- Downstream stage of the HCP local-access command encapsulator.
- Queues 64-bit encapsulated read-response commands (write strobe plus data) in a small FIFO.
- Batches them into byte-wide frames for the TSMP agent's output packet path.
- A frame is sent when a full batch is queued or when an idle timeout expires with a partial batch.

---
 rtl/command_frame_serializer_hcp.sv | 189 ++++++++++++++++++
 tb/tb_command_frame_serializer_hcp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/command_frame_serializer_hcp.sv
// rtl/command_frame_serializer_hcp.sv - HCP command FIFO batched into byte-wide frames
// Optional trailer checksum byte is enabled by defining HCP_FRAME_CHECKSUM_EN.
module command_frame_serializer_hcp #(
    parameter int FIFO_DEPTH     = 16,
    parameter int BATCH_NUM      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [63:0]                   iv_command,
    input  logic                          i_command_wr,
    output logic [7:0]                    ov_data,
    output logic                          o_data_valid,
    input  logic                          i_data_ready,
    output logic                          o_data_last,
    output logic [$clog2(FIFO_DEPTH):0]   ov_fifo_usedw,
    output logic                          o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int UW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [UW-1:0] BATCH    = UW'(BATCH_NUM);
    localparam logic [UW-1:0] DEPTH    = UW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, HEAD, BODY, TRAILER} state_t;

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [UW-1:0] usedw_q, usedw_d;
    logic          overflow_q;
    state_t        state_q;
    logic [UW-1:0] n_q, cmd_cnt_q;
    logic [2:0]    byte_idx_q;
    logic [63:0]   shift_q;
    logic [7:0]    data_q;
    logic          valid_q, last_q;
    logic [TW-1:0] tmo_q;
`ifdef HCP_FRAME_CHECKSUM_EN
    logic [7:0]    csum_q;
`endif

    logic          full, wr_accept, hs, more_cmds, pop, tmo_fire, start;
    logic [UW-1:0] n_start;
    logic [63:0]   head_word;

    assign full      = (usedw_q == DEPTH);
    assign wr_accept = i_command_wr && !full;
    assign hs        = valid_q && i_data_ready;
    assign more_cmds = (cmd_cnt_q + UW'(1)) < n_q;
    assign head_word = mem_q[rd_ptr_q];
    assign tmo_fire  = (tmo_q == TMO_LAST);
    assign start     = (usedw_q >= BATCH) || (tmo_fire && usedw_q != '0);
    assign n_start   = (usedw_q >= BATCH) ? BATCH : usedw_q;

    always_comb begin
        pop = 1'b0;
        if (hs) begin
            if (state_q == HEAD)
                pop = 1'b1;
            else if (state_q == BODY && byte_idx_q == 3'd7 && more_cmds)
                pop = 1'b1;
        end
    end

    assign usedw_d = usedw_q + UW'(wr_accept) - UW'(pop);

    always_ff @(posedge i_clk) begin
        if (wr_accept)
            mem_q[wr_ptr_q] <= iv_command;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + AW'(1);
            usedw_q    <= usedw_d;
            overflow_q <= i_command_wr && full;
        end
    end

    // Any accepted write restarts the idle window, so a partial batch waits
    // TIMEOUT_CYCLES after the most recent command rather than the first one.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            tmo_q <= '0;
        else if (state_q != IDLE || start || usedw_q == '0 || wr_accept)
            tmo_q <= '0;
        else
            tmo_q <= tmo_q + TW'(1);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            cmd_cnt_q  <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= HEAD;
                        n_q     <= n_start;
                        data_q  <= {4'hC, 4'(n_start)};
                        valid_q <= 1'b1;
                        last_q  <= 1'b0;
                    end
                end
                HEAD: begin
                    if (hs) begin
                        state_q    <= BODY;
                        shift_q    <= head_word;
                        data_q     <= head_word[63:56];
                        byte_idx_q <= '0;
                        cmd_cnt_q  <= '0;
                        last_q     <= 1'b0;
                    end
                end
                BODY: begin
                    if (hs) begin
                        if (byte_idx_q != 3'd7) begin
                            shift_q    <= {shift_q[55:0], 8'h00};
                            data_q     <= shift_q[55:48];
                            byte_idx_q <= byte_idx_q + 3'd1;
`ifdef HCP_FRAME_CHECKSUM_EN
                            last_q     <= 1'b0;
`else
                            last_q     <= (byte_idx_q == 3'd6) && !more_cmds;
`endif
                        end else if (more_cmds) begin
                            shift_q    <= head_word;
                            data_q     <= head_word[63:56];
                            byte_idx_q <= '0;
                            cmd_cnt_q  <= cmd_cnt_q + UW'(1);
                            last_q     <= 1'b0;
                        end else begin
`ifdef HCP_FRAME_CHECKSUM_EN
                            state_q    <= TRAILER;
                            data_q     <= csum_q ^ data_q;
                            last_q     <= 1'b1;
`else
                            state_q    <= IDLE;
                            valid_q    <= 1'b0;
                            last_q     <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    if (hs) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

`ifdef HCP_FRAME_CHECKSUM_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            csum_q <= '0;
        else if (hs && state_q == HEAD)
            csum_q <= data_q;
        else if (hs && state_q == BODY)
            csum_q <= csum_q ^ data_q;
    end
`endif

    assign ov_data       = data_q;
    assign o_data_valid  = valid_q;
    assign o_data_last   = last_q;
    assign ov_fifo_usedw = usedw_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_command_frame_serializer_hcp.sv
// tb/tb_command_frame_serializer_hcp.sv - self-checking bench for command_frame_serializer_hcp
module tb_command_frame_serializer_hcp;
    localparam int DEPTH = 16;
    localparam int BATCH = 8;
    localparam int TMO   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] iv_command;
    logic        i_command_wr;
    logic [7:0]  ov_data;
    logic        o_data_valid;
    logic        i_data_ready;
    logic        o_data_last;
    logic [4:0]  ov_fifo_usedw;
    logic        o_overflow;

    command_frame_serializer_hcp #(
        .FIFO_DEPTH(DEPTH), .BATCH_NUM(BATCH), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk), .i_rst(rst), .iv_command(iv_command), .i_command_wr(i_command_wr),
        .ov_data(ov_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .o_data_last(o_data_last), .ov_fifo_usedw(ov_fifo_usedw), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          last_wr = 0;
    logic [7:0]  last_byte;
    logic [63:0] mq[$];
    logic [7:0]  exp_b[$];
    logic        exp_l[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int frame_bytes(input int n);
`ifdef HCP_FRAME_CHECKSUM_EN
        return 2 + 8 * n;
`else
        return 1 + 8 * n;
`endif
    endfunction

    // Reference: a frame is a header then N commands MSB first, optionally an XOR trailer.
    task automatic model_frame(input int n);
        logic [7:0]  h, x, b;
        logic [63:0] c;
        h = 8'hC0 | 8'(n);
        x = h;
        exp_b.push_back(h);
        exp_l.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            c = mq.pop_front();
            for (int k = 7; k >= 0; k--) begin
                b = c[k*8 +: 8];
                x ^= b;
                exp_b.push_back(b);
`ifdef HCP_FRAME_CHECKSUM_EN
                exp_l.push_back(1'b0);
`else
                exp_l.push_back(i == n - 1 && k == 0);
`endif
            end
        end
`ifdef HCP_FRAME_CHECKSUM_EN
        exp_b.push_back(x);
        exp_l.push_back(1'b1);
`endif
    endtask

    task automatic wr(input logic [63:0] c);
        iv_command   = c;
        i_command_wr = 1'b1;
        last_wr      = cyc;
        @(posedge clk); #1;
        i_command_wr = 1'b0;
    endtask

    task automatic wait_hdr(input int ref_cyc, input int lat);
        int t = 0;
        while (!o_data_valid && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        chk("hdr_seen", 64'(o_data_valid), 64'd1);
        if (lat >= 0) chk("hdr_latency", 64'(cyc - ref_cyc), 64'(lat));
    endtask

    // mode 0: ready always, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int nbytes, input int mode);
        int         got = 0;
        logic       hold = 1'b0, in_frame = 1'b0, gap = 1'b0, r;
        logic [7:0] pd = '0, eb;
        logic       pl = 1'b0, el;
        for (int t = 0; t < 3000 && got < nbytes; t++) begin
            if (hold) begin
                chk("hold_valid", 64'(o_data_valid), 64'd1);
                chk("hold_data", 64'(ov_data), 64'(pd));
                chk("hold_last", 64'(o_data_last), 64'(pl));
            end else if (in_frame) begin
                chk("valid_in_frame", 64'(o_data_valid), 64'd1);
            end
            if (gap) chk("frame_gap", 64'(o_data_valid), 64'd0);
            case (mode)
                0:       r = 1'b1;
                1:       r = (t % 4 == 0) || (t % 4 == 3);
                default: r = 1'($urandom_range(0, 1));
            endcase
            i_data_ready = r;
            gap = 1'b0;
            if (o_data_valid && r) begin
                chk("exp_avail", 64'(exp_b.size() > 0), 64'd1);
                if (exp_b.size() > 0) begin
                    eb = exp_b.pop_front();
                    el = exp_l.pop_front();
                    chk("byte", 64'(ov_data), 64'(eb));
                    chk("last", 64'(o_data_last), 64'(el));
                end
                last_byte = ov_data;
                got++;
                in_frame = !o_data_last;
                gap = o_data_last;
            end
            hold = o_data_valid && !r;
            pd = ov_data;
            pl = o_data_last;
            @(posedge clk); #1;
        end
        i_data_ready = 1'b0;
        chk("drain_count", 64'(got), 64'(nbytes));
    endtask

    initial begin
        logic [63:0] c;
        int          k, total;
        rst = 1'b1;
        iv_command = '0;
        i_command_wr = 1'b0;
        i_data_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(o_data_valid), 64'd0);
        chk("rst_last", 64'(o_data_last), 64'd0);
        chk("rst_data", 64'(ov_data), 64'd0);
        chk("rst_usedw", 64'(ov_fifo_usedw), 64'd0);
        chk("rst_ovf", 64'(o_overflow), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // full batch
        for (int i = 0; i < 8; i++) begin
            c = 64'h0000_0001_0000_0000 + 64'(i);
            mq.push_back(c);
            wr(c);
        end
        wait_hdr(last_wr, 2);
        chk("hdr_c8", 64'(ov_data), 64'hC8);
        model_frame(8);
        drain(frame_bytes(8), 0);
        chk("full_usedw", 64'(ov_fifo_usedw), 64'd0);
        chk("full_idle", 64'(o_data_valid), 64'd0);

        // timeout flush with a partial batch
        for (int i = 0; i < 3; i++) begin
            c = {$urandom, $urandom};
            mq.push_back(c);
            wr(c);
        end
        wait_hdr(last_wr, TMO + 1);
        chk("hdr_c3", 64'(ov_data), 64'hC3);
        model_frame(3);
        drain(frame_bytes(3), 0);
        chk("tmo_usedw", 64'(ov_fifo_usedw), 64'd0);

        // backpressure on a one-command frame
        c = {$urandom, $urandom};
        mq.push_back(c);
        wr(c);
        wait_hdr(last_wr, TMO + 1);
        model_frame(1);
        drain(frame_bytes(1), 1);
        chk("bp_idle", 64'(o_data_valid), 64'd0);

        // overflow while the frame is stalled
        for (int i = 0; i < 17; i++) begin
            c = {$urandom, $urandom};
            if (i < 16) mq.push_back(c);
            wr(c);
            chk(i < 16 ? "ovf_quiet" : "ovf_pulse", 64'(o_overflow), (i < 16) ? 64'd0 : 64'd1);
        end
        chk("ovf_usedw", 64'(ov_fifo_usedw), 64'd16);
        @(posedge clk); #1;
        chk("ovf_single", 64'(o_overflow), 64'd0);
        model_frame(8);
        model_frame(8);
        drain(2 * frame_bytes(8), 2);
        chk("ovf_drained", 64'(ov_fifo_usedw), 64'd0);

        // asynchronous reset in the middle of a frame
        for (int i = 0; i < 8; i++) begin
            c = {$urandom, $urandom};
            mq.push_back(c);
            wr(c);
        end
        model_frame(8);
        drain(5, 0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(o_data_valid), 64'd0);
        chk("mid_rst_last", 64'(o_data_last), 64'd0);
        chk("mid_rst_usedw", 64'(ov_fifo_usedw), 64'd0);
        chk("mid_rst_ovf", 64'(o_overflow), 64'd0);
        exp_b.delete();
        exp_l.delete();
        mq.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        c = {$urandom, $urandom};
        mq.push_back(c);
        wr(c);
        wait_hdr(last_wr, TMO + 1);
        chk("post_rst_hdr", 64'(ov_data), 64'hC1);
        model_frame(1);
        drain(frame_bytes(1), 0);

        // known command: body ends in 08, trailer XOR is C9
        c = 64'h0102030405060708;
        mq.push_back(c);
        wr(c);
        wait_hdr(last_wr, TMO + 1);
        model_frame(1);
        drain(frame_bytes(1), 0);
`ifdef HCP_FRAME_CHECKSUM_EN
        chk("trailer", 64'(last_byte), 64'hC9);
`else
        chk("final_body", 64'(last_byte), 64'h08);
`endif

        // randomized bursts and ready patterns
        for (int it = 0; it < 6; it++) begin
            k = $urandom_range(1, 12);
            for (int i = 0; i < k; i++) begin
                c = {$urandom, $urandom};
                mq.push_back(c);
                wr(c);
            end
            model_frame(k > BATCH ? BATCH : k);
            total = frame_bytes(k > BATCH ? BATCH : k);
            if (k > BATCH) begin
                model_frame(k - BATCH);
                total += frame_bytes(k - BATCH);
            end
            drain(total, 2);
            chk("rand_usedw", 64'(ov_fifo_usedw), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
